axi_lite_mmio_master: RTL and testbench

AXI_LITE_MMIO_MASTER -- requirements
Module: axi_lite_mmio_master

---
 rtl/axi_lite_mmio_master.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_axi_lite_mmio_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mmio_master.sv
// ---------------------------------------------------------------------------
// axi_lite_mmio_master
//
// Converts single core MMIO requests into AXI4-Lite read or write
// transactions. Only one transaction is in flight at a time. Each
// handshake phase is guarded by a 16-bit cycle counter. If a phase does
// not complete within TIMEOUT_CYC cycles, the transaction is aborted and
// completes with DECERR and resp_timeout set.
//
// Ports
//   clk, arst        : clock; asynchronous active-high reset
//   req_*            : core request (valid/ready, write flag, addr, data, strobes)
//   resp_*           : one-cycle completion pulse with read data, AXI response
//                      code and timeout flag
//   M_AXI_aw*/w*/b*  : AXI4-Lite write address, write data and write response
//   M_AXI_ar*/r*     : AXI4-Lite read address and read data
// ---------------------------------------------------------------------------
module axi_lite_mmio_master #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        arst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_code,
    output logic        resp_timeout,

    output logic [7:0]  M_AXI_awaddr,
    output logic [2:0]  M_AXI_awprot,
    output logic        M_AXI_awvalid,
    input  logic        M_AXI_awready,

    output logic [31:0] M_AXI_wdata,
    output logic [3:0]  M_AXI_wstrb,
    output logic        M_AXI_wvalid,
    input  logic        M_AXI_wready,

    input  logic [1:0]  M_AXI_bresp,
    input  logic        M_AXI_bvalid,
    output logic        M_AXI_bready,

    output logic [7:0]  M_AXI_araddr,
    output logic [2:0]  M_AXI_arprot,
    output logic        M_AXI_arvalid,
    input  logic        M_AXI_arready,

    input  logic [31:0] M_AXI_rdata,
    input  logic [1:0]  M_AXI_rresp,
    input  logic        M_AXI_rvalid,
    output logic        M_AXI_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT_CYC);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_DEC   = 2'b11;

    state_t      state_r;
    logic        req_ready_r;
    logic [7:0]  addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic        bready_r;
    logic        arvalid_r;
    logic        rready_r;
    logic [15:0] cnt_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic [1:0]  resp_code_r;
    logic        resp_timeout_r;

    logic [15:0] cnt_inc_s;
    logic        tmo_hit_s;
    logic        aw_ok_s;
    logic        w_ok_s;

    // Phase-timeout detection and write-channel completion tracking.
    // aw_ok_s/w_ok_s include a handshake happening this cycle so that
    // AW and W completing together move on without an extra cycle.
    always_comb begin
        cnt_inc_s = cnt_r + 16'd1;
        tmo_hit_s = (cnt_inc_s == TIMEOUT_L);
        aw_ok_s   = aw_done_r | (awvalid_r & M_AXI_awready);
        w_ok_s    = w_done_r  | (wvalid_r  & M_AXI_wready);
    end

    // Transaction FSM. All outputs are registered here.
    // A handshake is tested before the timeout, so a handshake that completes
    // in the same cycle as the timeout takes priority.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r        <= IDLE;
            req_ready_r    <= 1'b1;
            addr_r         <= 8'd0;
            wdata_r        <= 32'd0;
            wstrb_r        <= 4'd0;
            awvalid_r      <= 1'b0;
            wvalid_r       <= 1'b0;
            aw_done_r      <= 1'b0;
            w_done_r       <= 1'b0;
            bready_r       <= 1'b0;
            arvalid_r      <= 1'b0;
            rready_r       <= 1'b0;
            cnt_r          <= 16'd0;
            resp_valid_r   <= 1'b0;
            resp_rdata_r   <= 32'd0;
            resp_code_r    <= RESP_OKAY;
            resp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 16'd0;
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        wstrb_r     <= req_wstrb;
                        if (req_write) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                            state_r   <= WR_REQ;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD_REQ;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end

                WR_REQ: begin
                    if (aw_ok_s && w_ok_s) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b0;
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        cnt_r     <= 16'd0;
                        state_r   <= WR_RESP;
                    end else if (tmo_hit_s) begin
                        awvalid_r      <= 1'b0;
                        wvalid_r       <= 1'b0;
                        aw_done_r      <= 1'b0;
                        w_done_r       <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_code_r    <= RESP_DEC;
                        resp_timeout_r <= 1'b1;
                        resp_rdata_r   <= 32'd0;
                        cnt_r          <= 16'd0;
                        state_r        <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                        // Each channel drops its valid right after its own handshake.
                        if (awvalid_r && M_AXI_awready) begin
                            awvalid_r <= 1'b0;
                            aw_done_r <= 1'b1;
                        end
                        if (wvalid_r && M_AXI_wready) begin
                            wvalid_r <= 1'b0;
                            w_done_r <= 1'b1;
                        end
                    end
                end

                WR_RESP: begin
                    if (M_AXI_bvalid) begin
                        bready_r       <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_code_r    <= M_AXI_bresp;
                        resp_timeout_r <= 1'b0;
                        resp_rdata_r   <= 32'd0;
                        cnt_r          <= 16'd0;
                        state_r        <= DONE;
                    end else if (tmo_hit_s) begin
                        bready_r       <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_code_r    <= RESP_DEC;
                        resp_timeout_r <= 1'b1;
                        resp_rdata_r   <= 32'd0;
                        cnt_r          <= 16'd0;
                        state_r        <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end

                RD_REQ: begin
                    if (M_AXI_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        cnt_r     <= 16'd0;
                        state_r   <= RD_RESP;
                    end else if (tmo_hit_s) begin
                        arvalid_r      <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_code_r    <= RESP_DEC;
                        resp_timeout_r <= 1'b1;
                        resp_rdata_r   <= 32'd0;
                        cnt_r          <= 16'd0;
                        state_r        <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end

                RD_RESP: begin
                    if (M_AXI_rvalid) begin
                        rready_r       <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_code_r    <= M_AXI_rresp;
                        resp_timeout_r <= 1'b0;
                        resp_rdata_r   <= M_AXI_rdata;
                        cnt_r          <= 16'd0;
                        state_r        <= DONE;
                    end else if (tmo_hit_s) begin
                        rready_r       <= 1'b0;
                        resp_valid_r   <= 1'b1;
                        resp_code_r    <= RESP_DEC;
                        resp_timeout_r <= 1'b1;
                        resp_rdata_r   <= 32'd0;
                        cnt_r          <= 16'd0;
                        state_r        <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end

                DONE: begin
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    cnt_r        <= 16'd0;
                    state_r      <= IDLE;
                end

                default: begin
                    // Unreachable encoding: return to a quiet idle state.
                    awvalid_r    <= 1'b0;
                    wvalid_r     <= 1'b0;
                    aw_done_r    <= 1'b0;
                    w_done_r     <= 1'b0;
                    bready_r     <= 1'b0;
                    arvalid_r    <= 1'b0;
                    rready_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    cnt_r        <= 16'd0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_rdata    = resp_rdata_r;
    assign resp_code     = resp_code_r;
    assign resp_timeout  = resp_timeout_r;

    assign M_AXI_awaddr  = addr_r;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awvalid = awvalid_r;
    assign M_AXI_wdata   = wdata_r;
    assign M_AXI_wstrb   = wstrb_r;
    assign M_AXI_wvalid  = wvalid_r;
    assign M_AXI_bready  = bready_r;
    assign M_AXI_araddr  = addr_r;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arvalid = arvalid_r;
    assign M_AXI_rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_mmio_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mmio_master
//
// Directed, cycle-accurate stimulus. The AXI slave side is driven by hand
// on the falling clock edge, and DUT outputs are sampled on the falling
// edge. The DUT is built with TIMEOUT_CYC = 8.
// ---------------------------------------------------------------------------
module tb_axi_lite_mmio_master;

    logic        clk;
    logic        arst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_code;
    logic        resp_timeout;
    logic [7:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int err_cnt  = 0;
    int chk_cnt  = 0;
    int resp_cnt = 0;

    axi_lite_mmio_master #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_code(resp_code),
        .resp_timeout(resp_timeout),
        .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid),
        .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid),
        .M_AXI_wready(wready),
        .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
        .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid),
        .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid),
        .M_AXI_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count resp_valid cycles. The count is taken on the rising edge, so a
    // pulse is counted at the edge that ends the DONE cycle.
    always @(posedge clk) begin
        if (resp_valid === 1'b1) resp_cnt <= resp_cnt + 1;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one request for a single cycle. The DUT must be idle when this
    // task is called. It returns on the falling edge after acceptance.
    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
        req_wdata = 32'h0; req_wstrb = 4'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

        // ---------------- reset state ----------------
        repeat (2) tick();
        check_eq("rst_req_ready", req_ready, 32'd1);
        check_eq("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        check_eq("rst_resp", {resp_valid, resp_timeout, resp_code}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_addr_data", {awaddr, wdata[23:0]}, 32'd0);
        arst = 1'b0;
        tick();

        // ---------------- write, AW and W together ----------------
        issue(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
        check_eq("w1_valids", {awvalid, wvalid, req_ready}, 32'b110);
        check_eq("w1_awaddr", awaddr, 32'h04);
        check_eq("w1_wdata", wdata, 32'hDEADBEEF);
        check_eq("w1_wstrb_prot", {wstrb, awprot, arprot}, 32'h3C0);
        tick();
        check_eq("w1_stable_valid", {awvalid, wvalid}, 32'b11);
        check_eq("w1_stable_pay", {awaddr, wdata[23:0]}, 32'h04ADBEEF);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        check_eq("w1_resp_phase", {awvalid, wvalid, bready}, 32'b001);
        tick();
        check_eq("w1_bready_wait", bready, 32'd1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check_eq("w1_done", {resp_valid, resp_timeout, resp_code, bready}, 32'b10000);
        check_eq("w1_rdata", resp_rdata, 32'd0);
        tick();
        check_eq("w1_pulse_end", {resp_valid, req_ready}, 32'b01);
        check_eq("w1_resp_cnt", resp_cnt, 32'd1);

        // ---------------- write, W three cycles before AW ----------------
        issue(1'b1, 8'h08, 32'hA5A55A5A, 4'h3);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check_eq("w2_w_dropped", {awvalid, wvalid}, 32'b10);
        tick();
        check_eq("w2_aw_held", {awvalid, wvalid, bready}, 32'b100);
        tick();
        check_eq("w2_aw_held2", {awvalid, awaddr}, 32'h108);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check_eq("w2_resp_phase", {awvalid, wvalid, bready}, 32'b001);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check_eq("w2_done", {resp_valid, resp_timeout, resp_code, bready}, 32'b10000);
        tick();
        check_eq("w2_single_pulse", {resp_valid, bready}, 32'b00);
        check_eq("w2_resp_cnt", resp_cnt, 32'd2);

        // ---------------- read, arready delayed 5 cycles, SLVERR ----------------
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        check_eq("r1_araddr", {arvalid, araddr}, 32'h110);
        for (int i = 0; i < 5; i++) begin
            check_eq("r1_ar_held", {arvalid, rready}, 32'b10);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_eq("r1_rd_phase", {arvalid, rready}, 32'b01);
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
        tick();
        rvalid = 1'b0;
        check_eq("r1_done", {resp_valid, resp_timeout, resp_code, rready}, 32'b10100);
        check_eq("r1_rdata", resp_rdata, 32'h12345678);
        // A stray response while idle must be ignored.
        bvalid = 1'b1; rvalid = 1'b1; rdata = 32'hFFFFFFFF;
        tick();
        tick();
        check_eq("stray_ignored", {bready, rready, resp_valid, req_ready}, 32'b0001);
        bvalid = 1'b0; rvalid = 1'b0;
        check_eq("r1_resp_cnt", resp_cnt, 32'd3);

        // ---------------- read timeout (arready never asserted) ----------------
        issue(1'b0, 8'h20, 32'h0, 4'h0);
        for (int i = 0; i < 7; i++) tick();
        check_eq("t1_ar_cycle8", arvalid, 32'd1);
        tick();
        check_eq("t1_ar_dropped", {arvalid, rready}, 32'b00);
        check_eq("t1_done", {resp_valid, resp_timeout, resp_code}, 32'b1111);
        check_eq("t1_rdata_zero", resp_rdata, 32'd0);
        tick();
        check_eq("t1_resp_cnt", resp_cnt, 32'd4);

        // ---------------- handshake on the timeout cycle takes priority ----------------
        issue(1'b0, 8'h24, 32'h0, 4'h0);
        for (int i = 0; i < 7; i++) tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_eq("t2_hs_wins", {arvalid, rready, resp_valid}, 32'b010);
        rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check_eq("t2_done", {resp_valid, resp_timeout, resp_code}, 32'b1000);
        check_eq("t2_rdata", resp_rdata, 32'hCAFEF00D);
        tick();

        // ---------------- reset asserted during WR_RESP ----------------
        issue(1'b1, 8'h0C, 32'h11223344, 4'hF);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        check_eq("rs_in_wr_resp", bready, 32'd1);
        #2;
        arst = 1'b1;
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        check_eq("rs_async_outs", {bready, awvalid, wvalid, resp_valid, req_ready}, 32'b00001);
        check_eq("rs_async_regs", {awaddr, wdata[23:0]}, 32'd0);
        tick();
        tick();
        arst = 1'b0;
        bvalid = 1'b0;
        tick();
        check_eq("rs_no_resp", {resp_valid, bready, req_ready}, 32'b001);
        check_eq("rs_resp_cnt", resp_cnt, 32'd5);
        issue(1'b0, 8'h30, 32'h0, 4'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check_eq("rs_next_ok", {resp_valid, resp_timeout, resp_code}, 32'b1000);
        check_eq("rs_next_rdata", resp_rdata, 32'h0BADF00D);
        tick();

        // ---------------- back-to-back with req_valid held ----------------
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40;
        req_wdata = 32'h00000001; req_wstrb = 4'hF;
        tick();
        check_eq("bb_first_acc", {awvalid, wvalid, req_ready}, 32'b110);
        req_write = 1'b0; req_addr = 8'h44;
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        check_eq("bb_busy_resp", {req_ready, arvalid, bready}, 32'b001);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        check_eq("bb_first_done", {resp_valid, req_ready, arvalid}, 32'b100);
        tick();
        check_eq("bb_idle", {req_ready, arvalid, awvalid}, 32'b100);
        tick();
        req_valid = 1'b0;
        check_eq("bb_second_acc", {arvalid, awvalid, req_ready, araddr}, 32'h444);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h5555AAAA; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check_eq("bb_second_done", {resp_valid, resp_code}, 32'b100);
        check_eq("bb_second_rdata", resp_rdata, 32'h5555AAAA);
        tick();
        check_eq("bb_resp_cnt", resp_cnt, 32'd8);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
